// File: rtl/vga_pattern_gen.sv
// Pixel source for the VGA timing driver: black, colour bars, checkerboard or bouncing box.
// Box state advances once per frame on the vsync falling edge so the picture never tears.
module vga_pattern_gen #(
   parameter int unsigned H_DISP   = 640,
   parameter int unsigned V_DISP   = 480,
   parameter int unsigned BOX_W    = 64,
   parameter int unsigned BOX_H    = 48,
   parameter int unsigned STEP_X   = 4,
   parameter int unsigned STEP_Y   = 3,
   parameter logic [11:0] BG_COLOR = 12'h008
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic        vga_vs,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic [1:0]  mode,
   input  logic        pause,
   output logic [11:0] pixel_data,
   output logic        frame_tick
);

   localparam logic [10:0] XMax  = 11'(H_DISP - BOX_W);
   localparam logic [10:0] YMax  = 11'(V_DISP - BOX_H);
   localparam logic [10:0] StepX = 11'(STEP_X);
   localparam logic [10:0] StepY = 11'(STEP_Y);
   localparam logic [10:0] BoxW  = 11'(BOX_W);
   localparam logic [10:0] BoxH  = 11'(BOX_H);
   localparam int unsigned BarW  = H_DISP / 8;

   function automatic logic [11:0] palette(input logic [2:0] idx);
      logic [11:0] c;
      case (idx)
         3'd0:    c = 12'hF00;
         3'd1:    c = 12'h0F0;
         3'd2:    c = 12'h00F;
         3'd3:    c = 12'hFF0;
         3'd4:    c = 12'h0FF;
         3'd5:    c = 12'hF0F;
         3'd6:    c = 12'hFFF;
         default: c = 12'hF80;
      endcase
      return c;
   endfunction

   logic        vs_q, tick_q;
   logic [1:0]  mode_q;
   logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
   logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic [2:0]  color_q, color_d;
   logic [11:0] pix_q, pix_d;
   logic        bounce_x, bounce_y;
   logic [10:0] nx, ny, px, py;
   logic [2:0]  bar_idx;
   logic        bar_valid, in_box;

   // Box motion: next position/direction, applied only on an unpaused frame tick.
   always_comb begin
      box_x_d  = box_x_q;
      dir_x_d  = dir_x_q;
      bounce_x = 1'b0;
      nx       = box_x_q + StepX;
      if (dir_x_q) begin
         if (nx >= XMax) begin
            box_x_d  = XMax;
            dir_x_d  = 1'b0;
            bounce_x = 1'b1;
         end else begin
            box_x_d = nx;
         end
      end else if (box_x_q <= StepX) begin
         box_x_d  = '0;
         dir_x_d  = 1'b1;
         bounce_x = 1'b1;
      end else begin
         box_x_d = box_x_q - StepX;
      end

      box_y_d  = box_y_q;
      dir_y_d  = dir_y_q;
      bounce_y = 1'b0;
      ny       = box_y_q + StepY;
      if (dir_y_q) begin
         if (ny >= YMax) begin
            box_y_d  = YMax;
            dir_y_d  = 1'b0;
            bounce_y = 1'b1;
         end else begin
            box_y_d = ny;
         end
      end else if (box_y_q <= StepY) begin
         box_y_d  = '0;
         dir_y_d  = 1'b1;
         bounce_y = 1'b1;
      end else begin
         box_y_d = box_y_q - StepY;
      end

      color_d = color_q + {2'b00, bounce_x | bounce_y};
   end

   // Pixel path; bar index from a comparator chain, smallest matching bar wins.
   always_comb begin
      px        = {1'b0, pixel_x};
      py        = {1'b0, pixel_y};
      bar_valid = px < 11'(H_DISP);
      bar_idx   = 3'd7;
      for (int k = 6; k >= 0; k--) begin
         if (px < 11'((k + 1) * BarW)) bar_idx = 3'(k);
      end
      in_box = (px >= box_x_q) && (px < box_x_q + BoxW) &&
               (py >= box_y_q) && (py < box_y_q + BoxH);
      pix_d = 12'h000;
      unique case (mode_q)
         2'd0: pix_d = 12'h000;
         2'd1: pix_d = bar_valid ? palette(bar_idx) : 12'h000;
         2'd2: pix_d = (pixel_x[5] ^ pixel_y[5]) ? 12'h000 : 12'hFFF;
         2'd3: pix_d = in_box ? palette(color_q) : BG_COLOR;
      endcase
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vs_q    <= 1'b1;
         tick_q  <= 1'b0;
         mode_q  <= 2'd0;
         box_x_q <= '0;
         box_y_q <= '0;
         dir_x_q <= 1'b1;
         dir_y_q <= 1'b1;
         color_q <= 3'd0;
         pix_q   <= 12'h000;
      end else begin
         vs_q   <= vga_vs;
         tick_q <= vs_q & ~vga_vs;
         pix_q  <= pix_d;
         if (tick_q) begin
            mode_q <= mode;
            if (!pause) begin
               box_x_q <= box_x_d;
               box_y_q <= box_y_d;
               dir_x_q <= dir_x_d;
               dir_y_q <= dir_y_d;
               color_q <= color_d;
            end
         end
      end
   end

   assign pixel_data = pix_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen: an arithmetic reference model checked every cycle,
// plus directed scenarios with literal expectations for bars, ticks, bounces and pause.
module tb_vga_pattern_gen;

   localparam int XLim = 640 - 64;
   localparam int YLim = 480 - 48;

   logic        vga_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        vga_vs = 1'b1;
   logic [9:0]  pixel_x = '0;
   logic [9:0]  pixel_y = '0;
   logic [1:0]  mode = 2'd0;
   logic        pause = 1'b0;
   logic [11:0] pixel_data;
   logic        frame_tick;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 0;

   vga_pattern_gen dut (
      .vga_clk    (vga_clk),
      .sys_rst_n  (sys_rst_n),
      .vga_vs     (vga_vs),
      .pixel_x    (pixel_x),
      .pixel_y    (pixel_y),
      .mode       (mode),
      .pause      (pause),
      .pixel_data (pixel_data),
      .frame_tick (frame_tick)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic logic [11:0] pal(input int i);
      logic [11:0] t [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                             12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};
      return t[i % 8];
   endfunction

   function automatic logic [11:0] ref_pix(input int x, input int y, input int md,
                                           input int bx, input int by, input int ci);
      case (md)
         1:       return (x < 640) ? pal(x / 80) : 12'h000;
         2:       return (((x / 32) + (y / 32)) % 2 == 0) ? 12'hFFF : 12'h000;
         3:       return (x >= bx && x < bx + 64 && y >= by && y < by + 48) ? pal(ci) : 12'h008;
         default: return 12'h000;
      endcase
   endfunction

   // Reference model state
   int          m_bx, m_by, m_dx, m_dy, m_ci, m_mode, m_vs, m_tick;
   logic [11:0] m_pix;
   int          n_bx, n_by, n_dx, n_dy;
   bit          bnc;
   logic [11:0] m_pix_nxt;

   always_comb begin
      n_bx = m_bx; n_dx = m_dx; n_by = m_by; n_dy = m_dy; bnc = 1'b0;
      if (m_dx == 1) begin
         if (m_bx + 4 >= XLim) begin n_bx = XLim; n_dx = 0; bnc = 1'b1; end
         else n_bx = m_bx + 4;
      end else if (m_bx <= 4) begin n_bx = 0; n_dx = 1; bnc = 1'b1; end
      else n_bx = m_bx - 4;
      if (m_dy == 1) begin
         if (m_by + 3 >= YLim) begin n_by = YLim; n_dy = 0; bnc = 1'b1; end
         else n_by = m_by + 3;
      end else if (m_by <= 3) begin n_by = 0; n_dy = 1; bnc = 1'b1; end
      else n_by = m_by - 3;
      m_pix_nxt = ref_pix(int'(pixel_x), int'(pixel_y), m_mode, m_bx, m_by, m_ci);
   end

   always @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         m_pix <= 12'h000; m_tick <= 0; m_vs <= 1; m_mode <= 0;
         m_bx <= 0; m_by <= 0; m_dx <= 1; m_dy <= 1; m_ci <= 0;
      end else begin
         m_pix  <= m_pix_nxt;
         m_vs   <= int'(vga_vs);
         m_tick <= (m_vs == 1 && vga_vs == 1'b0) ? 1 : 0;
         if (m_tick == 1) begin
            m_mode <= int'(mode);
            if (!pause) begin
               m_bx <= n_bx; m_by <= n_by; m_dx <= n_dx; m_dy <= n_dy;
               m_ci <= bnc ? (m_ci + 1) % 8 : m_ci;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   initial forever begin
      @(negedge vga_clk);
      if (sys_rst_n && started) begin
         n_checks++;
         if (pixel_data !== m_pix) begin
            n_fail++;
            $display("FAIL pixel_data t=%0t got %h want %h", $time, pixel_data, m_pix);
         end
         n_checks++;
         if (frame_tick !== (m_tick == 1)) begin
            n_fail++;
            $display("FAIL frame_tick t=%0t got %b want %0d", $time, frame_tick, m_tick);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic rand_cycle();
      pixel_x = 10'($urandom_range(0, 700));
      pixel_y = 10'($urandom_range(0, 520));
      @(negedge vga_clk);
   endtask

   task automatic do_frame(input int len);
      vga_vs = 1'b0;
      repeat (2) rand_cycle();
      vga_vs = 1'b1;
      repeat (len - 2) rand_cycle();
   endtask

   task automatic probe(input int x, input int y, input logic [11:0] exp, input string nm);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      @(negedge vga_clk);
      chk(nm, int'(pixel_data), int'(exp));
   endtask

   task automatic do_reset();
      @(negedge vga_clk);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("reset_pixel", int'(pixel_data), 0);
      chk("reset_tick", int'(frame_tick), 0);
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
   endtask

   int ticks;

   initial begin
      repeat (2) @(negedge vga_clk);
      sys_rst_n = 1'b1;
      started = 1;
      probe(5, 5, 12'h000, "post_reset_black");

      // Tick timing: one pulse for a held-low vsync, none on the rising edge
      vga_vs = 1'b0;
      @(negedge vga_clk);
      chk("tick_first", int'(frame_tick), 1);
      ticks = 0;
      repeat (4) begin @(negedge vga_clk); ticks += int'(frame_tick); end
      vga_vs = 1'b1;
      repeat (3) begin @(negedge vga_clk); ticks += int'(frame_tick); end
      chk("tick_extra", ticks, 0);

      // Colour bars with latency check, then mode change taking effect on the next tick
      mode = 2'd1;
      do_frame(4);
      for (int x = 0; x < 640; x++) begin
         pixel_x = 10'(x);
         @(negedge vga_clk);
         if (x == 79)  chk("bar_x79", int'(pixel_data), 'hF00);
         if (x == 80)  chk("bar_x80", int'(pixel_data), 'h0F0);
         if (x == 639) chk("bar_x639", int'(pixel_data), 'hF80);
      end
      mode = 2'd0;
      probe(100, 0, 12'h0F0, "bars_persist");
      do_frame(4);
      probe(100, 0, 12'h000, "mode0_black");

      // Checkerboard then mid-run reset; box mode stays black until the first tick
      mode = 2'd2;
      do_frame(4);
      probe(0, 0, 12'hFFF, "checker_00");
      probe(32, 0, 12'h000, "checker_32");
      mode = 2'd3;
      do_reset();
      repeat (3) probe(0, 0, 12'h000, "box_wait_black");

      // 144 frames: simultaneous X/Y bounce advances colour once
      repeat (144) do_frame(6);
      chk("model_bx144", m_bx, 576);
      chk("model_by144", m_by, 432);
      chk("model_ci144", m_ci, 1);
      probe(576, 432, 12'h0F0, "box_corner_in");
      probe(575, 432, 12'h008, "box_corner_out");

      // Back to the left wall
      repeat (143) do_frame(5);
      chk("model_bx_left", m_bx, 4);
      probe(4, m_by, 12'h0F0, "box_left_in");
      probe(3, m_by, 12'h008, "box_left_out");
      do_frame(5);
      chk("model_bx_wall", m_bx, 0);
      chk("model_ci_wall", m_ci, 2);
      probe(0, 0, 12'h00F, "box_wall_colour");
      do_frame(5);
      chk("model_bx_after", m_bx, 4);

      // Pause holds position and colour
      do_reset();
      repeat (10) do_frame(4);
      pause = 1'b1;
      repeat (10) do_frame(4);
      chk("model_bx_pause", m_bx, 40);
      probe(40, 30, 12'hF00, "pause_in");
      probe(39, 30, 12'h008, "pause_out");
      pause = 1'b0;
      do_frame(4);
      chk("model_bx_resume", m_bx, 44);
      probe(44, 33, 12'hF00, "resume_in");
      probe(43, 33, 12'h008, "resume_out");

      // Random frames, modes, pause and one mid-run reset
      for (int f = 0; f < 250; f++) begin
         mode  = 2'($urandom_range(0, 3));
         pause = ($urandom_range(0, 3) == 0);
         if (f == 120) do_reset();
         do_frame($urandom_range(3, 20));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
